sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller command port between three requesters: the ROM loader (byte writes during download), the cartridge ROM read path (halfword reads), and the backup-save port (byte read/write). It sits between the loader, `gba_top`, and `sdram`. It serializes these requesters into one-at-a-time transactions, with fixed priority plus anti-starvation aging for the save port. During download, only the loader is served.

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM command-port arbiter.
`timescale 1ns/1ps
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    PORT_LD,
    PORT_CART,
    PORT_SV
  } arb_port_t;

  // Byte lane enable for a byte access within a 16-bit SDRAM word.
  function automatic logic [1:0] be_from_a0(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// Serializes loader writes, cart halfword reads and save byte accesses onto
// the single SDRAM command port: fixed priority with aging for the save port.
`timescale 1ns/1ps
//   state   | meaning
//   IDLE    | arbitrate between requesters
//   ISSUE   | mem_valid high, command held until mem_ready
//   WAIT_RD | read accepted, waiting for mem_rvalid
//   DONE    | one-cycle ack pulse to the served port
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                ADDR_W    = 25,
  parameter int                SAVE_AW   = 17,
  parameter logic [ADDR_W-1:0] SAVE_BASE = 25'h1FE0000,
  parameter int                MAX_WAIT  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              cart_req,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [15:0]       cart_rdata,
  output logic              cart_ack,
  input  logic              sv_req,
  input  logic              sv_we,
  input  logic [SAVE_AW-1:0] sv_addr,
  input  logic [7:0]        sv_wdata,
  output logic [7:0]        sv_rdata,
  output logic              sv_ack,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              stray_rvalid
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  arb_port_t         port_q, port_d;
  logic [WAIT_W-1:0] save_wait_q, save_wait_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              ld_ack_q, ld_ack_d;
  logic              cart_ack_q, cart_ack_d;
  logic              sv_ack_q, sv_ack_d;
  logic [15:0]       cart_rdata_q, cart_rdata_d;
  logic [7:0]        sv_rdata_q, sv_rdata_d;
  logic              stray_q, stray_d;

  logic              grant_valid;
  arb_port_t         grant_port;
  logic              finish;
  logic [ADDR_W-1:0] sv_mem_addr;
  logic              unused_cart_a0;

  assign sv_mem_addr    = SAVE_BASE + ADDR_W'(sv_addr);
  assign unused_cart_a0 = cart_addr[0];

  // Save port jumps ahead of the cart once it has watched MAX_WAIT cart grants.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_LD;
    if (dl_active) begin
      if (ld_req) begin
        grant_valid = 1'b1;
        grant_port  = PORT_LD;
      end
    end else if (sv_req && (save_wait_q == WAIT_MAX)) begin
      grant_valid = 1'b1;
      grant_port  = PORT_SV;
    end else if (cart_req) begin
      grant_valid = 1'b1;
      grant_port  = PORT_CART;
    end else if (sv_req) begin
      grant_valid = 1'b1;
      grant_port  = PORT_SV;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    save_wait_d  = save_wait_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    cart_rdata_d = cart_rdata_q;
    sv_rdata_d   = sv_rdata_q;
    stray_d      = stray_q | (mem_rvalid && (state_q != WAIT_RD));
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d     = ISSUE;
          port_d      = grant_port;
          mem_valid_d = 1'b1;
          case (grant_port)
            PORT_LD: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = ld_addr;
              mem_be_d    = be_from_a0(ld_addr[0]);
              mem_wdata_d = {ld_data, ld_data};
            end
            PORT_CART: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = {cart_addr[ADDR_W-1:1], 1'b0};
              mem_be_d    = 2'b11;
              mem_wdata_d = 16'h0000;
              if (sv_req && (save_wait_q != WAIT_MAX)) begin
                save_wait_d = save_wait_q + 1'b1;
              end
            end
            default: begin
              mem_we_d    = sv_we;
              mem_addr_d  = sv_mem_addr;
              mem_be_d    = be_from_a0(sv_addr[0]);
              mem_wdata_d = {sv_wdata, sv_wdata};
              save_wait_d = '0;
            end
          endcase
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_we_q) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          state_d = DONE;
          finish  = 1'b1;
          if (port_q == PORT_CART) begin
            cart_rdata_d = mem_rdata;
          end else if (port_q == PORT_SV) begin
            sv_rdata_d = mem_be_q[1] ? mem_rdata[15:8] : mem_rdata[7:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ld_ack_d   = finish && (port_q == PORT_LD);
    cart_ack_d = finish && (port_q == PORT_CART);
    sv_ack_d   = finish && (port_q == PORT_SV);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port_q       <= PORT_LD;
      save_wait_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 2'b00;
      mem_wdata_q  <= 16'h0000;
      ld_ack_q     <= 1'b0;
      cart_ack_q   <= 1'b0;
      sv_ack_q     <= 1'b0;
      cart_rdata_q <= 16'h0000;
      sv_rdata_q   <= 8'h00;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      save_wait_q  <= save_wait_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      ld_ack_q     <= ld_ack_d;
      cart_ack_q   <= cart_ack_d;
      sv_ack_q     <= sv_ack_d;
      cart_rdata_q <= cart_rdata_d;
      sv_rdata_q   <= sv_rdata_d;
      stray_q      <= stray_d;
    end
  end

  assign ld_ack       = ld_ack_q;
  assign cart_ack     = cart_ack_q;
  assign sv_ack       = sv_ack_q;
  assign cart_rdata   = cart_rdata_q;
  assign sv_rdata     = sv_rdata_q;
  assign mem_valid    = mem_valid_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign stray_rvalid = stray_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scenario bench for sdram_port_arbiter against a byte-memory model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int          ADDR_W    = 25;
  localparam int          SAVE_AW   = 17;
  localparam logic [24:0] SAVE_BASE = 25'h1FE0000;
  localparam int          MAX_WAIT  = 4;
  localparam int P_LD = 0, P_CART = 1, P_SV = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        ld_req = 1'b0, ld_ack;
  logic [24:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        cart_req = 1'b0, cart_ack;
  logic [24:0] cart_addr = '0;
  logic [15:0] cart_rdata;
  logic        sv_req = 1'b0, sv_we = 1'b0, sv_ack;
  logic [16:0] sv_addr = '0;
  logic [7:0]  sv_wdata = '0, sv_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid, stray_rvalid;
  logic [24:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [7:0]  smem[logic [24:0]];
  bit          rdy_rand = 1'b0;
  bit          resp_en = 1'b1;
  bit          fix_en = 1'b0;
  logic [15:0] fix_data = '0;
  int          rd_lat_fix = 0;
  int          rd_cnt = -1;
  logic [15:0] rd_word = '0;
  bit          inject_rv = 1'b0;
  int          last_rvalid_cyc = 0;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .SAVE_AW(SAVE_AW), .SAVE_BASE(SAVE_BASE), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .cart_req(cart_req), .cart_addr(cart_addr), .cart_rdata(cart_rdata), .cart_ack(cart_ack),
    .sv_req(sv_req), .sv_we(sv_we), .sv_addr(sv_addr), .sv_wdata(sv_wdata),
    .sv_rdata(sv_rdata), .sv_ack(sv_ack),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stray_rvalid(stray_rvalid)
  );

  always #5 clk_sys = ~clk_sys;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input logic [24:0] a);
    if (smem.exists(a)) return smem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] word_of(input logic [24:0] a);
    return {byte_of({a[24:1], 1'b1}), byte_of({a[24:1], 1'b0})};
  endfunction

  // Expected command a port should produce, straight from the address/lane rules.
  function automatic cmd_t exp_cmd(input int port, input logic we, input logic [24:0] a,
                                   input logic [7:0] d);
    cmd_t c;
    logic [24:0] sa;
    sa = SAVE_BASE + {8'h00, a[16:0]};
    case (port)
      P_LD:    c = '{1'b1, a, (a[0] ? 2'b10 : 2'b01), {d, d}};
      P_CART:  c = '{1'b0, {a[24:1], 1'b0}, 2'b11, 16'h0000};
      default: c = '{we, sa, (a[0] ? 2'b10 : 2'b01), (we ? {d, d} : 16'h0000)};
    endcase
    return c;
  endfunction

  function automatic logic [43:0] cmd_bits(input cmd_t c);
    return {c.we, c.addr, c.be, (c.we ? c.wdata : 16'h0000)};
  endfunction

  // SDRAM side: accepts commands, stores writes, returns reads after a latency.
  initial begin
    cmd_t c;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk_sys);
      mem_rvalid = 1'b0;
      if (inject_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata = 16'h0BAD;
        inject_rv = 1'b0;
        last_rvalid_cyc = cyc;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_word;
          last_rvalid_cyc = cyc;
          rd_cnt = -1;
        end
      end
      mem_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (reset_n && mem_valid && mem_ready) begin
        c = '{mem_we, mem_addr, mem_be, mem_wdata};
        cmd_q.push_back(c);
        if (mem_we) begin
          if (mem_be[0]) smem[{mem_addr[24:1], 1'b0}] = mem_wdata[7:0];
          if (mem_be[1]) smem[{mem_addr[24:1], 1'b1}] = mem_wdata[15:8];
        end else if (resp_en) begin
          rd_word = fix_en ? fix_data : word_of(mem_addr);
          rd_cnt = (rd_lat_fix > 0) ? rd_lat_fix : int'($urandom_range(1, 6));
        end
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    dl_active = 1'b0; ld_req = 1'b0; cart_req = 1'b0; sv_req = 1'b0;
    rd_cnt = -1; inject_rv = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // One transaction on one port; returns cycles from drive to ack.
  task automatic xact(input int port, input logic we, input logic [24:0] a, input logic [7:0] d,
                      output int lat, output bit to);
    int t0;
    case (port)
      P_LD:    begin ld_addr = a; ld_data = d; ld_req = 1'b1; end
      P_CART:  begin cart_addr = a; cart_req = 1'b1; end
      default: begin sv_addr = a[16:0]; sv_we = we; sv_wdata = d; sv_req = 1'b1; end
    endcase
    t0 = cyc; to = 1'b1; lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if ((port == P_LD && ld_ack) || (port == P_CART && cart_ack) || (port == P_SV && sv_ack)) begin
        to = 1'b0;
        lat = cyc - t0;
        break;
      end
    end
    ld_req = 1'b0; cart_req = 1'b0; sv_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({mem_valid, mem_we, mem_be} !== 4'b0) begin
      n_err++; $display("FAIL reset_mem_ctl: got %b expected 0000", {mem_valid, mem_we, mem_be});
    end
    n_chk++;
    if ({mem_addr, mem_wdata} !== 41'h0) begin
      n_err++; $display("FAIL reset_mem_fields: got %h expected 0", {mem_addr, mem_wdata});
    end
    n_chk++;
    if ({ld_ack, cart_ack, sv_ack, stray_rvalid} !== 4'b0) begin
      n_err++; $display("FAIL reset_acks: got %b expected 0000", {ld_ack, cart_ack, sv_ack, stray_rvalid});
    end
    n_chk++;
    if ({cart_rdata, sv_rdata} !== 24'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h expected 0", {cart_rdata, sv_rdata});
    end
  endtask

  task automatic test_loader();
    int lat; bit to; cmd_t e;
    dl_active = 1'b1; rdy_rand = 1'b0; rd_lat_fix = 0;
    cmd_q.delete();
    for (int i = 0; i < 4; i++) begin
      xact(P_LD, 1'b1, 25'(i), 8'(8'hA0 + i), lat, to);
      e = exp_cmd(P_LD, 1'b1, 25'(i), 8'(8'hA0 + i));
      n_chk++;
      if (to || lat != ((i == 0) ? 2 : 3)) begin
        n_err++; $display("FAIL ld_latency[%0d]: got %0d (timeout=%0d) expected %0d", i, lat, to, (i == 0) ? 2 : 3);
      end
      n_chk++;
      if (cmd_q.size() != i + 1) begin
        n_err++; $display("FAIL ld_cmd_count[%0d]: got %0d expected %0d", i, cmd_q.size(), i + 1);
      end else if (cmd_bits(cmd_q[i]) !== cmd_bits(e)) begin
        n_err++; $display("FAIL ld_cmd[%0d]: got %h expected %h", i, cmd_bits(cmd_q[i]), cmd_bits(e));
      end
    end
    dl_active = 1'b0;
  endtask

  task automatic test_cart_read();
    int lat; bit to;
    @(negedge clk_sys);
    cmd_q.delete();
    rd_lat_fix = 5; fix_en = 1'b1; fix_data = 16'hBEEF;
    xact(P_CART, 1'b0, 25'h0000101, 8'h00, lat, to);
    n_chk++;
    if (to || cyc != last_rvalid_cyc + 1) begin
      n_err++; $display("FAIL cart_ack_timing: got cycle %0d (timeout=%0d) expected %0d", cyc, to, last_rvalid_cyc + 1);
    end
    n_chk++;
    if (cmd_q.size() != 1 || cmd_bits(cmd_q[0]) !== {1'b0, 25'h0000100, 2'b11, 16'h0}) begin
      n_err++; $display("FAIL cart_cmd: got %0d cmds, first %h expected addr 0000100 be 11 rd",
                        cmd_q.size(), (cmd_q.size() > 0) ? cmd_bits(cmd_q[0]) : 44'h0);
    end
    n_chk++;
    if (cart_rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL cart_rdata: got %h expected beef", cart_rdata);
    end
    fix_en = 1'b0; rd_lat_fix = 0;
  endtask

  task automatic test_save_rw();
    int lat; bit to; cmd_t e;
    logic [16:0] tbl[4];
    logic [16:0] a;
    logic [7:0]  d;
    tbl = '{17'h00000, 17'h00001, 17'h1FFFF, 17'h1FFFE};
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = (i < 4) ? tbl[i] : 17'($urandom);
      d = 8'($urandom);
      @(negedge clk_sys);
      cmd_q.delete();
      xact(P_SV, 1'b1, {8'h00, a}, d, lat, to);
      e = exp_cmd(P_SV, 1'b1, {8'h00, a}, d);
      n_chk++;
      if (to || cmd_q.size() != 1 || cmd_bits(cmd_q[0]) !== cmd_bits(e)) begin
        n_err++; $display("FAIL sv_write_cmd[%0d]: got %h (n=%0d timeout=%0d) expected %h", i,
                          (cmd_q.size() > 0) ? cmd_bits(cmd_q[0]) : 44'h0, cmd_q.size(), to, cmd_bits(e));
      end
      @(negedge clk_sys);
      xact(P_SV, 1'b0, {8'h00, a}, 8'h00, lat, to);
      n_chk++;
      if (to || sv_rdata !== d) begin
        n_err++; $display("FAIL sv_readback[%0d]: got %h (timeout=%0d) expected %h", i, sv_rdata, to, d);
      end
    end
    rdy_rand = 1'b0;
  endtask

  task automatic test_random();
    int lat; bit to; cmd_t e; int port; logic we; logic [24:0] a; logic [7:0] d;
    logic [15:0] ew; int n0;
    rdy_rand = 1'b1; rd_lat_fix = 0;
    for (int i = 0; i < 30; i++) begin
      port = int'($urandom_range(0, 2));
      we   = (port == P_LD) ? 1'b1 : (port == P_CART) ? 1'b0 : 1'($urandom_range(0, 1));
      a    = (port == P_SV) ? {8'h00, 17'($urandom)} : 25'($urandom);
      d    = 8'($urandom);
      dl_active = (port == P_LD);
      @(negedge clk_sys);
      e  = exp_cmd(port, we, a, d);
      ew = word_of(e.addr);
      n0 = cmd_q.size();
      xact(port, we, a, d, lat, to);
      n_chk++;
      if (to || cmd_q.size() != n0 + 1 || cmd_bits(cmd_q[n0]) !== cmd_bits(e)) begin
        n_err++; $display("FAIL rand_cmd[%0d]: port %0d got %h (n=%0d timeout=%0d) expected %h", i, port,
                          (cmd_q.size() > n0) ? cmd_bits(cmd_q[n0]) : 44'h0, cmd_q.size() - n0, to, cmd_bits(e));
      end
      if (port == P_CART) begin
        n_chk++;
        if (cart_rdata !== ew) begin
          n_err++; $display("FAIL rand_cart_rdata[%0d]: got %h expected %h", i, cart_rdata, ew);
        end
      end else if (port == P_SV && !we) begin
        n_chk++;
        if (sv_rdata !== (a[0] ? ew[15:8] : ew[7:0])) begin
          n_err++; $display("FAIL rand_sv_rdata[%0d]: got %h expected %h", i, sv_rdata, a[0] ? ew[15:8] : ew[7:0]);
        end
      end
    end
    dl_active = 1'b0; rdy_rand = 1'b0;
    n_chk++;
    if (stray_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rand_no_stray: got %b expected 0", stray_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic [24:0] ca; logic [16:0] sa; logic [7:0] sd; cmd_t e; int w; bit exp_sv;
    apply_reset();
    rd_lat_fix = 1;
    cmd_q.delete();
    ca = 25'($urandom); sa = 17'($urandom); sd = 8'($urandom);
    cart_addr = ca; cart_req = 1'b1;
    sv_addr = sa; sv_we = 1'b1; sv_wdata = sd; sv_req = 1'b1;
    for (int i = 0; i < 400 && cmd_q.size() < 10; i++) @(negedge clk_sys);
    cart_req = 1'b0; sv_req = 1'b0;
    repeat (20) @(negedge clk_sys);
    n_chk++;
    if (cmd_q.size() < 10) begin
      n_err++; $display("FAIL starve_count: got %0d grants expected at least 10", cmd_q.size());
    end
    w = 0;
    for (int i = 0; i < 10 && i < cmd_q.size(); i++) begin
      exp_sv = (w == MAX_WAIT);
      e = exp_sv ? exp_cmd(P_SV, 1'b1, {8'h00, sa}, sd) : exp_cmd(P_CART, 1'b0, ca, 8'h00);
      n_chk++;
      if (cmd_bits(cmd_q[i]) !== cmd_bits(e)) begin
        n_err++; $display("FAIL starve_grant[%0d]: got %h expected %h (%s)", i, cmd_bits(cmd_q[i]),
                          cmd_bits(e), exp_sv ? "save" : "cart");
      end
      w = exp_sv ? 0 : ((w < MAX_WAIT) ? w + 1 : w);
    end
    rd_lat_fix = 0;
  endtask

  task automatic test_dl_gating();
    int acks; bit got;
    apply_reset();
    cmd_q.delete();
    dl_active = 1'b1;
    cart_addr = 25'($urandom); cart_req = 1'b1;
    sv_addr = 17'($urandom); sv_we = 1'b0; sv_req = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk_sys);
      acks += int'(cart_ack) + int'(sv_ack);
    end
    n_chk++;
    if (acks != 0 || cmd_q.size() != 0) begin
      n_err++; $display("FAIL dl_gate_idle: got %0d acks %0d cmds expected 0 0", acks, cmd_q.size());
    end
    dl_active = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (cart_ack) begin got = 1'b1; break; end
    end
    cart_req = 1'b0;
    n_chk++;
    if (!got || cmd_q.size() < 1 || cmd_q[0].be !== 2'b11 || cmd_q[0].we !== 1'b0) begin
      n_err++; $display("FAIL dl_gate_cart_first: got ack=%0d be %b expected ack=1 be 11", got,
                        (cmd_q.size() > 0) ? cmd_q[0].be : 2'b00);
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (sv_ack) begin got = 1'b1; break; end
    end
    sv_req = 1'b0;
    n_chk++;
    if (!got || cmd_q.size() != 2 || cmd_q[1].addr !== SAVE_BASE + {8'h00, sv_addr}) begin
      n_err++; $display("FAIL dl_gate_save_next: got ack=%0d n=%0d expected ack=1 n=2", got, cmd_q.size());
    end
  endtask

  task automatic test_dl_mid_read();
    logic [24:0] ca, la; logic [15:0] ew; bit got; int bad_acks, ld_acks, bad_cmds;
    @(negedge clk_sys);
    cmd_q.delete();
    rd_lat_fix = 10;
    ca = 25'($urandom); la = 25'($urandom);
    ew = word_of({ca[24:1], 1'b0});
    cart_addr = ca; cart_req = 1'b1;
    for (int i = 0; i < 50 && cmd_q.size() == 0; i++) @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    dl_active = 1'b1;
    ld_addr = la; ld_data = 8'h3C; ld_req = 1'b1;
    sv_addr = 17'($urandom); sv_we = 1'b0; sv_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (cart_ack) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got || cart_rdata !== ew) begin
      n_err++; $display("FAIL dl_mid_cart_done: got ack=%0d data %h expected ack=1 data %h", got, cart_rdata, ew);
    end
    bad_acks = 0; ld_acks = 0;
    repeat (30) begin
      @(negedge clk_sys);
      bad_acks += int'(cart_ack) + int'(sv_ack);
      ld_acks  += int'(ld_ack);
    end
    ld_req = 1'b0; cart_req = 1'b0; sv_req = 1'b0;
    repeat (5) @(negedge clk_sys);
    dl_active = 1'b0;
    bad_cmds = 0;
    for (int i = 1; i < cmd_q.size(); i++)
      if (cmd_q[i].we !== 1'b1 || cmd_q[i].addr !== la) bad_cmds++;
    n_chk++;
    if (bad_acks != 0 || bad_cmds != 0 || ld_acks < 5) begin
      n_err++; $display("FAIL dl_mid_loader_only: got %0d other acks %0d other cmds %0d ld acks expected 0 0 >=5",
                        bad_acks, bad_cmds, ld_acks);
    end
    rd_lat_fix = 0;
  endtask

  task automatic test_reset_wait_rd();
    int acks;
    repeat (3) @(negedge clk_sys);
    resp_en = 1'b0;
    cmd_q.delete();
    cart_addr = 25'($urandom); cart_req = 1'b1;
    for (int i = 0; i < 50 && cmd_q.size() == 0; i++) @(negedge clk_sys);
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    cart_req = 1'b0;
    #1;
    n_chk++;
    if ({mem_valid, mem_we, mem_be, mem_addr, mem_wdata, ld_ack, cart_ack, sv_ack,
         cart_rdata, sv_rdata, stray_rvalid} !== 73'h0) begin
      n_err++; $display("FAIL rst_wait_rd_outputs: got valid=%b addr=%h cart_rdata=%h stray=%b expected all 0",
                        mem_valid, mem_addr, cart_rdata, stray_rvalid);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk_sys);
      acks += int'(ld_ack) + int'(cart_ack) + int'(sv_ack);
    end
    n_chk++;
    if (acks != 0 || stray_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_rd_no_ack: got %0d acks stray=%b expected 0 0", acks, stray_rvalid);
    end
    inject_rv = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_chk++;
    if (stray_rvalid !== 1'b1) begin
      n_err++; $display("FAIL stray_rvalid: got %b expected 1", stray_rvalid);
    end
    resp_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_loader();
    test_cart_read();
    test_save_rw();
    test_random();
    test_starvation();
    test_dl_gating();
    test_dl_mid_read();
    test_reset_wait_rd();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
